// File: rtl/accum_seq.sv
// Accumulator sequencer: walks n_terms passes over n_pos psum positions, issues psum
// reads/write-backs and accumulator flags. Option macro: ACCUM_SEQ_SKIP_FIRST_READ_EN.
module accum_seq #(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned AWIDTH = 10,
    parameter int unsigned CWIDTH = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CWIDTH-1:0] n_pos,
    input  logic [CWIDTH-1:0] n_terms,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              psum_re,
    output logic [AWIDTH-1:0] psum_raddr,
    output logic              psum_we,
    output logic [AWIDTH-1:0] psum_waddr,
    output logic              acc_init,
    output logic              acc_we,
    output logic              busy,
    output logic              done
);

    // Out-of-range read latency falls back to a single stage
    localparam int unsigned       LAT   = (RD_LAT >= 1 && RD_LAT <= 3 && DWIDTH > 0) ? RD_LAT : 1;
    localparam logic [CWIDTH-1:0] LAT_C = CWIDTH'(LAT);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            r_state, w_next;
    logic [CWIDTH-1:0] r_npos, r_nterms, r_p, r_k;
    logic [AWIDTH-1:0] r_base;
    logic [LAT-1:0]    r_tv, r_tf, r_tl;
    logic [AWIDTH-1:0] r_ta [LAT];

    logic w_accept, w_plast, w_klast, w_first, w_inflight, w_pend, w_hazard, w_zero;

    always_comb begin
        w_plast    = (r_p == r_npos - 1'b1);
        w_klast    = (r_k == r_nterms - 1'b1);
        w_first    = (r_k == '0);
        w_zero     = (n_pos == '0) || (n_terms == '0);
        w_inflight = |r_tv;
        // Tags still queued behind the stage that is writing back this cycle
        w_pend     = 1'b0;
        for (int unsigned i = 0; i + 1 < LAT; i++) begin
            w_pend = w_pend | r_tv[i];
        end
        w_hazard   = (r_npos <= LAT_C) && w_inflight;
        in_ready   = (r_state == S_RUN) && !w_hazard;
        w_accept   = in_valid && in_ready;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = w_zero ? S_DONE : S_RUN;
            S_RUN:   if (w_accept && w_plast && w_klast) w_next = S_DRAIN;
            S_DRAIN: if (!w_pend) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
`ifdef ACCUM_SEQ_SKIP_FIRST_READ_EN
        psum_re = w_accept && !w_first;
`else
        psum_re = w_accept;
`endif
        psum_raddr = r_base + AWIDTH'(r_p);
        psum_we    = r_tv[LAT-1];
        psum_waddr = r_ta[LAT-1];
        acc_init   = r_tv[LAT-1] & r_tf[LAT-1];
        acc_we     = r_tv[LAT-1] & r_tl[LAT-1];
        busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
        done       = (r_state == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_npos   <= '0;
            r_nterms <= '0;
            r_base   <= '0;
            r_p      <= '0;
            r_k      <= '0;
            r_tv     <= '0;
            r_tf     <= '0;
            r_tl     <= '0;
            for (int unsigned i = 0; i < LAT; i++) r_ta[i] <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_npos   <= n_pos;
                r_nterms <= n_terms;
                r_base   <= base_addr;
                r_p      <= '0;
                r_k      <= '0;
            end else if (w_accept) begin
                if (w_plast) begin
                    r_p <= '0;
                    r_k <= r_k + 1'b1;
                end else begin
                    r_p <= r_p + 1'b1;
                end
            end
            r_tv[0] <= w_accept;
            r_ta[0] <= psum_raddr;
            r_tf[0] <= w_first;
            r_tl[0] <= w_klast;
            for (int unsigned i = 1; i < LAT; i++) begin
                r_tv[i] <= r_tv[i-1];
                r_ta[i] <= r_ta[i-1];
                r_tf[i] <= r_tf[i-1];
                r_tl[i] <= r_tl[i-1];
            end
        end
    end

endmodule

// File: tb/tb_accum_seq.sv
// Bench for accum_seq: two instances (RD_LAT=1 and RD_LAT=2) share stimulus and are
// checked every cycle against a job-level reference model.
module tb_accum_seq;

`ifdef ACCUM_SEQ_SKIP_FIRST_READ_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] n_pos, n_terms;
    logic [9:0] base_addr;
    logic       in_valid;

    logic [1:0] rdy, re, we, ini, awe, bsy, dn;
    logic [9:0] raddr [2];
    logic [9:0] waddr [2];

    always #5 clk = ~clk;

    accum_seq #(.DWIDTH(16), .AWIDTH(10), .CWIDTH(8), .RD_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .n_pos(n_pos), .n_terms(n_terms),
        .base_addr(base_addr), .in_valid(in_valid), .in_ready(rdy[0]), .psum_re(re[0]),
        .psum_raddr(raddr[0]), .psum_we(we[0]), .psum_waddr(waddr[0]), .acc_init(ini[0]),
        .acc_we(awe[0]), .busy(bsy[0]), .done(dn[0]));

    accum_seq #(.DWIDTH(16), .AWIDTH(10), .CWIDTH(8), .RD_LAT(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start), .n_pos(n_pos), .n_terms(n_terms),
        .base_addr(base_addr), .in_valid(in_valid), .in_ready(rdy[1]), .psum_re(re[1]),
        .psum_raddr(raddr[1]), .psum_we(we[1]), .psum_waddr(waddr[1]), .acc_init(ini[1]),
        .acc_we(awe[1]), .busy(bsy[1]), .done(dn[1]));

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int d, input int act, input int exp);
        n_tot++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s dut%0d t=%0t: got %0h want %0h", nm, d, $time, act, exp);
        end
    endtask

    // Reference model: a job is an ordered list of npos*nterms beats; each accepted
    // beat becomes a write-back due a fixed latency later.
    typedef struct {
        int       due;
        int       addr;
        bit       first;
        bit       last;
    } wb_t;

    wb_t wq [2][$];
    bit  m_busy [2];
    bit  m_idle [2];
    int  m_idx [2], m_total [2], m_npos [2], m_nterms [2], m_base [2], m_done_at [2];
    int  wb_seen [2], done_seen [2];
    int  cyc = 0;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    task automatic model_step(input int d);
        bit exp_rdy, acc, exp_re, exp_we;
        int p, k, exp_raddr;
        wb_t e;
        if (reset) begin
            chk("rst_ready", d, int'(rdy[d]), 0);
            chk("rst_re", d, int'(re[d]), 0);
            chk("rst_we", d, int'(we[d]), 0);
            chk("rst_init", d, int'(ini[d]), 0);
            chk("rst_accwe", d, int'(awe[d]), 0);
            chk("rst_busy", d, int'(bsy[d]), 0);
            chk("rst_done", d, int'(dn[d]), 0);
            wq[d].delete();
            m_busy[d] = 0;
            m_idle[d] = 1;
            m_done_at[d] = -10;
            return;
        end
        exp_rdy = m_busy[d] && (m_idx[d] < m_total[d]) &&
                  !((m_npos[d] <= lat_of(d)) && (wq[d].size() > 0));
        acc = exp_rdy && in_valid;
        p = 0; k = 0;
        if (m_npos[d] != 0) begin
            p = m_idx[d] % m_npos[d];
            k = m_idx[d] / m_npos[d];
        end
        exp_raddr = (m_base[d] + p) % 1024;
        exp_re = acc && !(SKIP && k == 0);
        exp_we = (wq[d].size() > 0) && (wq[d][0].due == cyc);

        chk("in_ready", d, int'(rdy[d]), int'(exp_rdy));
        chk("psum_re", d, int'(re[d]), int'(exp_re));
        if (acc) chk("psum_raddr", d, int'(raddr[d]), exp_raddr);
        chk("psum_we", d, int'(we[d]), int'(exp_we));
        if (exp_we) chk("psum_waddr", d, int'(waddr[d]), wq[d][0].addr);
        chk("acc_init", d, int'(ini[d]), exp_we ? int'(wq[d][0].first) : 0);
        chk("acc_we", d, int'(awe[d]), exp_we ? int'(wq[d][0].last) : 0);
        chk("busy", d, int'(bsy[d]), int'(m_busy[d]));
        chk("done", d, int'(dn[d]), int'(cyc == m_done_at[d]));
        if (we[d]) wb_seen[d]++;
        if (dn[d]) done_seen[d]++;

        if (exp_we) void'(wq[d].pop_front());
        if (acc) begin
            e.due = cyc + lat_of(d);
            e.addr = exp_raddr;
            e.first = (k == 0);
            e.last = (k == m_nterms[d] - 1);
            wq[d].push_back(e);
            m_idx[d]++;
        end
        if (m_busy[d] && m_idx[d] == m_total[d] && wq[d].size() == 0) begin
            m_busy[d] = 0;
            m_done_at[d] = cyc + 1;
        end
        if (m_idle[d] && start) begin
            m_npos[d] = int'(n_pos);
            m_nterms[d] = int'(n_terms);
            m_base[d] = int'(base_addr);
            m_idx[d] = 0;
            m_total[d] = m_npos[d] * m_nterms[d];
            if (m_total[d] == 0) m_done_at[d] = cyc + 1;
            else m_busy[d] = 1;
        end
        m_idle[d] = !m_busy[d] && (cyc + 1 != m_done_at[d]);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = 0; m_idle[d] = 1; m_done_at[d] = -10;
            m_idx[d] = 0; m_total[d] = 0; m_npos[d] = 0; m_nterms[d] = 0; m_base[d] = 0;
            wb_seen[d] = 0; done_seen[d] = 0;
        end
    end

    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) model_step(d);
    end

    typedef struct {
        int npos;
        int nterms;
        int base;
        int vpct;
        int exp_wb;
    } vec_t;

    vec_t tbl [10];

    task automatic wait_idle(input int limit);
        int n = 0;
        while (!(m_idle[0] && m_idle[1]) && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        if (!(m_idle[0] && m_idle[1])) begin
            n_tot++; n_bad++;
            $display("FAIL idle_timeout: still busy after %0d cycles, want idle", limit);
        end
    endtask

    task automatic run_job(input vec_t v);
        wait_idle(50);
        for (int d = 0; d < 2; d++) begin
            wb_seen[d] = 0;
            done_seen[d] = 0;
        end
        @(posedge clk); #1;
        start = 1'b1;
        n_pos = 8'(v.npos);
        n_terms = 8'(v.nterms);
        base_addr = 10'(v.base);
        in_valid = ($urandom_range(0, 99) < v.vpct);
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 4000 && !(m_idle[0] && m_idle[1]); n++) begin
            in_valid = ($urandom_range(0, 99) < v.vpct);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_idle(10);
        for (int d = 0; d < 2; d++) begin
            chk("wb_count", d, wb_seen[d], v.exp_wb);
            chk("done_count", d, done_seen[d], 1);
        end
    endtask

    task automatic reset_mid_run();
        wait_idle(50);
        @(posedge clk); #1;
        start = 1'b1; n_pos = 8'd6; n_terms = 8'd4; base_addr = 10'h040; in_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("midrst_busy", d, int'(bsy[d]), 0);
            chk("midrst_ready", d, int'(rdy[d]), 0);
            chk("midrst_re", d, int'(re[d]), 0);
            chk("midrst_raddr", d, int'(raddr[d]), 0);
            chk("midrst_we", d, int'(we[d]), 0);
            chk("midrst_waddr", d, int'(waddr[d]), 0);
            chk("midrst_init", d, int'(ini[d]), 0);
            chk("midrst_accwe", d, int'(awe[d]), 0);
            chk("midrst_done", d, int'(dn[d]), 0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        tbl[0] = '{npos: 4, nterms: 3, base: 'h010, vpct: 100, exp_wb: 12};
        tbl[1] = '{npos: 1, nterms: 4, base: 'h020, vpct: 100, exp_wb: 4};
        tbl[2] = '{npos: 2, nterms: 1, base: 'h005, vpct: 100, exp_wb: 2};
        tbl[3] = '{npos: 0, nterms: 3, base: 'h000, vpct: 100, exp_wb: 0};
        tbl[4] = '{npos: 4, nterms: 2, base: 'h3FE, vpct: 100, exp_wb: 8};
        tbl[5] = '{npos: 5, nterms: 0, base: 'h100, vpct: 100, exp_wb: 0};
        tbl[6] = '{npos: 7, nterms: 3, base: int'($urandom_range(0, 1023)), vpct: 60, exp_wb: 21};
        tbl[7] = '{npos: 3, nterms: 5, base: int'($urandom_range(0, 1023)), vpct: 40, exp_wb: 15};
        tbl[8] = '{npos: 2, nterms: 2, base: int'($urandom_range(0, 1023)), vpct: 70, exp_wb: 4};
        tbl[9] = '{npos: 1, nterms: 1, base: int'($urandom_range(0, 1023)), vpct: 50, exp_wb: 1};

        reset = 1'b1;
        start = 1'b0;
        n_pos = '0;
        n_terms = '0;
        base_addr = '0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        run_job(tbl[0]);
        run_job(tbl[1]);
        reset_mid_run();
        for (int i = 0; i < 10; i++) run_job(tbl[i]);
        for (int r = 0; r < 6; r++) begin
            vec_t v;
            v.npos = int'($urandom_range(1, 9));
            v.nterms = int'($urandom_range(1, 4));
            v.base = int'($urandom_range(0, 1023));
            v.vpct = int'($urandom_range(30, 100));
            v.exp_wb = v.npos * v.nterms;
            run_job(v);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
